audio_stream_arbiter: RTL and testbench
=======================================

Name: audio_stream_arbiter

Overview:
- Shares one 64-bit AXI4-Stream playback path (toward the DMA→CODEC output FIFO) between NUM_SRC sample-voice/stream requesters.
- Sources are granted round-robin.
- A grant is held for a whole packet (tlast) or MAX_BURST beats, whichever comes first.
- Output is a registered AXIS stage; all logic runs in the AXI clock domain.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 64, stream data width (stereo sample pair)
MAX_BURST, 16, max beats per grant before forced release (>=1)

Ports:
- clock  input  1  AXI-domain clock
- reset  input  1  asynchronous, active-high reset
- src_enable  input  NUM_SRC  per-source enable; a disabled source is never granted
- s_axis_tvalid  input  NUM_SRC  per-source valid
- s_axis_tready  output  NUM_SRC  per-source ready
- s_axis_tdata  input  NUM_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
- s_axis_tlast  input  NUM_SRC  per-source end of packet
- m_axis_tvalid  output  1  merged stream valid
- m_axis_tready  input  1  merged stream ready (from output FIFO)
- m_axis_tdata  output  DATA_W  merged stream data
- m_axis_tlast  output  1  merged end of packet; set on forced release or source tlast
- grant_active  output  1  FSM is in GRANT
- grant_id  output  $clog2(NUM_SRC)  currently/last granted source
- beat_total  output  32  accepted output beats, wraps at 2^32

Behaviour:
- Reset (async, active-high), all outputs and state:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
  - s_axis_tready=0, grant_active=0, grant_id=0, beat_total=0
  - burst counter=0, last_grant=NUM_SRC-1, so src 0 has first priority.
- FSM states: IDLE, GRANT.
- IDLE:
  - Request vector req = s_axis_tvalid & src_enable.
  - If req≠0, pick the first set bit searching from last_grant+1 with wrap-around.
  - Register it into grant_id and last_grant, clear the burst counter, go to GRANT next cycle.
  - All s_axis_tready=0 in IDLE.
- GRANT, ready rule:
  - s_axis_tready[grant_id] = src_enable[grant_id] & (~m_axis_tvalid | m_axis_tready).
  - All other s_axis_tready=0.
- GRANT, beat acceptance: a beat is accepted when tvalid & tready on the granted source. On acceptance:
  - m_axis_tdata <= src data.
  - m_axis_tvalid <= 1.
  - m_axis_tlast <= src tlast | (burst==MAX_BURST-1).
  - burst counter increments.
- Output stage:
  - If no beat is accepted and m_axis_tready=1, m_axis_tvalid <= 0.
  - m_axis_tdata/m_axis_tlast hold while m_axis_tvalid & ~m_axis_tready.
- Latency: source beat appears on m_axis one cycle after acceptance. Full throughput (1 beat/cycle) within a grant.
- GRANT exit, go to IDLE next cycle when either:
  - an accepted beat has src tlast=1, or
  - an accepted beat brings the burst counter to MAX_BURST.
- Source disable: if src_enable[grant_id] deasserts in GRANT, its tready drops the same cycle and the FSM goes to IDLE next cycle. No beat is lost, because only handshaken beats are transferred. m_axis_tlast is not forced in this case.
- Bubble: exactly one idle cycle between grants (the IDLE arbitration cycle). Deliberate; the 48 kHz sample rate makes this irrelevant.
- Backpressure:
  - m_axis_tready=0 with m_axis_tvalid=1 holds the output.
  - Granted source sees tready=0 and the FSM stays in GRANT.
  - The burst counter does not advance.
- No requesters: stays in IDLE and m_axis_tvalid drains to 0.
- Single requester: re-granted after each release (round-robin wraps to itself).
- Counter wrap: beat_total increments on m_axis_tvalid & m_axis_tready and wraps 0xFFFF_FFFF→0.
- Burst counter width: $clog2(MAX_BURST+1).
- Reset mid-packet: output is dropped immediately; the source packet is not resumed.

Decomposition:
- audio_unit_pkg:
  - arb_state_t enum {IDLE, GRANT}
  - default constants AUDIO_DATA_W=64, ARB_MAX_BURST=16
- One sub-module: rr_priority_picker, combinational.
  - Inputs: req[NUM_SRC], last_grant.
  - Outputs: pick index, any.
- FSM, output register and counters stay in audio_stream_arbiter.

Test Plan:
- Reset check: src 0 and src 2 valid, all enabled, m_axis_tready=1, first release after reset → src 0 granted first (grant_id=0), src 2 next. Each sends 3-beat packets 0xA0..A2 / 0xC0..C2 → output A0,A1,A2(tlast),C0,C1,C2(tlast), one bubble cycle between packets.
- Forced release: src 1 streams 20 beats with no tlast, MAX_BURST=16 → m_axis_tlast on beat 16. FSM returns to IDLE, then re-grants src 1 for the remaining 4 beats. beat_total=20.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a packet → output data stable while stalled, no beat duplicated or dropped, burst counter frozen.
- Source disable: src_enable[3] cleared mid-packet after 2 beats → s_axis_tready[3]=0 that cycle, grant moves to next requester. Output tlast not set on beat 2.
- Fairness: all 4 sources continuously valid with 1-beat packets → grant_id sequence 0,1,2,3,0,1,… over 16 grants.
- Async reset mid-packet: assert reset during GRANT → m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, arbitration restarts at src 0.

Source files
------------

// File: rtl/audio_unit_pkg.sv
// rtl/audio_unit_pkg.sv - shared types and defaults for the audio stream arbiter
package audio_unit_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int AUDIO_DATA_W  = 64;
  localparam int ARB_MAX_BURST = 16;

endpackage

// File: rtl/audio_stream_arbiter_if.sv
// rtl/audio_stream_arbiter_if.sv - per-source input streams and merged output stream
interface audio_stream_arbiter_if
  import audio_unit_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = AUDIO_DATA_W
);

  logic [NUM_SRC-1:0]        src_enable;
  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tlast;

  modport master (
    input  src_enable, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output src_enable, s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick starting after last_grant
module rr_priority_picker #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic [$clog2(NUM_SRC)-1:0] pick,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam logic [IDX_W:0] NUM_SRC_W = (IDX_W+1)'(NUM_SRC);

  // One extra bit so last_grant + k never overflows before the manual wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (cand >= NUM_SRC_W) begin
        cand = cand - NUM_SRC_W;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any  = 1'b1;
        pick = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/audio_stream_arbiter.sv
// rtl/audio_stream_arbiter.sv - round-robin packet/burst arbiter onto one registered output stream
module audio_stream_arbiter
  import audio_unit_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = AUDIO_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                       clock,
  input  logic                       reset,
  audio_stream_arbiter_if.master     axis,
  output logic                       grant_active,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic [31:0]                beat_total
);

  localparam int IDX_W   = $clog2(NUM_SRC);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]   last_grant;
  logic [BURST_W-1:0] burst;
  logic [NUM_SRC-1:0] req;
  logic [IDX_W-1:0]   pick;
  logic               any;

  logic               sel_valid;
  logic               sel_last;
  logic               sel_enable;
  logic [DATA_W-1:0]  sel_data;
  logic               out_ready;
  logic               grant_ok;
  logic               accept;
  logic               burst_end;
  logic               pkt_end;
  logic [NUM_SRC-1:0] tready_vec;

  logic               m_valid_q;
  logic [DATA_W-1:0]  m_data_q;
  logic               m_last_q;

  assign req = axis.s_axis_tvalid & axis.src_enable;

  rr_priority_picker #(
    .NUM_SRC(NUM_SRC)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  assign sel_valid  = axis.s_axis_tvalid[grant_id];
  assign sel_last   = axis.s_axis_tlast[grant_id];
  assign sel_enable = axis.src_enable[grant_id];
  assign sel_data   = axis.s_axis_tdata[grant_id*DATA_W +: DATA_W];

  // Output slot is free when empty or being drained this cycle.
  assign out_ready = ~m_valid_q | axis.m_axis_tready;
  assign grant_ok  = (state == GRANT) & sel_enable & out_ready;
  assign accept    = grant_ok & sel_valid;
  assign burst_end = (burst == BURST_LAST);
  assign pkt_end   = accept & (sel_last | burst_end);

  always_comb begin
    tready_vec = '0;
    if (grant_ok) begin
      tready_vec[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = GRANT;
      GRANT:   if (!sel_enable || pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      burst      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) begin
        grant_id   <= pick;
        last_grant <= pick;
        burst      <= '0;
      end else if (accept) begin
        burst <= burst + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_last_q  <= sel_last | burst_end;
    end else if (axis.m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_total <= '0;
    end else if (m_valid_q && axis.m_axis_tready) begin
      beat_total <= beat_total + 32'd1;
    end
  end

  assign axis.s_axis_tready = tready_vec;
  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign grant_active       = (state == GRANT);

endmodule

// File: tb/tb_audio_stream_arbiter.sv
// tb/tb_audio_stream_arbiter.sv - directed self-checking bench for audio_stream_arbiter
module tb_audio_stream_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int QD = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        grant_active;
  logic [1:0]  grant_id;
  logic [31:0] beat_total;

  audio_stream_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) axis ();

  audio_stream_arbiter #(
    .NUM_SRC   (NS),
    .DATA_W    (DW),
    .MAX_BURST (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .axis         (axis),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .beat_total   (beat_total)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sdat [NS][QD];
  bit          slst [NS][QD];
  int          wp [NS];
  int          rp [NS];

  logic [63:0] out_data[$];
  bit          out_last[$];
  int          out_cyc[$];
  int          grant_log[$];
  logic [63:0] exp_data[$];
  bit          exp_last[$];

  int          cyc;
  bit          prev_active;
  logic [NS-1:0] hs;
  logic [63:0] smp_mdata;
  logic        smp_mvalid;
  logic [NS-1:0] smp_sready;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NS; i++) begin
      axis.s_axis_tvalid[i]         = (rp[i] < wp[i]);
      axis.s_axis_tdata[i*DW +: DW] = (rp[i] < wp[i]) ? sdat[i][rp[i]] : 64'h0;
      axis.s_axis_tlast[i]          = (rp[i] < wp[i]) ? slst[i][rp[i]] : 1'b0;
    end
  endtask

  task automatic push_beat(input int src, input logic [63:0] d, input bit l);
    sdat[src][wp[src]] = d;
    slst[src][wp[src]] = l;
    wp[src]++;
  endtask

  task automatic expect_beat(input logic [63:0] d, input bit l);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  task automatic clear_logs();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    grant_log.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  // Sample at negedge, advance source queues just after the following posedge.
  task automatic tick();
    @(negedge clock);
    hs         = axis.s_axis_tvalid & axis.s_axis_tready;
    smp_mdata  = axis.m_axis_tdata;
    smp_mvalid = axis.m_axis_tvalid;
    smp_sready = axis.s_axis_tready;
    if (axis.m_axis_tvalid && axis.m_axis_tready) begin
      out_data.push_back(axis.m_axis_tdata);
      out_last.push_back(axis.m_axis_tlast);
      out_cyc.push_back(cyc);
    end
    if (grant_active && !prev_active) grant_log.push_back(int'(grant_id));
    prev_active = grant_active;
    @(posedge clock);
    #1;
    for (int i = 0; i < NS; i++) if (hs[i]) rp[i]++;
    drive_sources();
    cyc++;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    axis.m_axis_tready = 1'b1;
    axis.src_enable    = '1;
    for (int i = 0; i < NS; i++) begin
      rp[i] = 0;
      wp[i] = 0;
    end
    drive_sources();
    clear_logs();
    prev_active = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic check_stream(input string tag);
    check_val({tag, "_count"}, out_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size(); i++) begin
      if (i < out_data.size()) begin
        check_val($sformatf("%s_data%0d", tag, i), out_data[i], exp_data[i]);
        check_val($sformatf("%s_last%0d", tag, i), out_last[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then src 0 and src 2 three-beat packets.
    do_reset();
    check_val("rst_mvalid", axis.m_axis_tvalid, 0);
    check_val("rst_mdata", axis.m_axis_tdata, 0);
    check_val("rst_mlast", axis.m_axis_tlast, 0);
    check_val("rst_sready", axis.s_axis_tready, 0);
    check_val("rst_gactive", grant_active, 0);
    check_val("rst_gid", grant_id, 0);
    check_val("rst_beats", beat_total, 0);
    for (int j = 0; j < 3; j++) begin
      push_beat(0, 64'hA0 + j, j == 2);
      push_beat(2, 64'hC0 + j, j == 2);
    end
    drive_sources();
    for (int j = 0; j < 3; j++) expect_beat(64'hA0 + j, j == 2);
    for (int j = 0; j < 3; j++) expect_beat(64'hC0 + j, j == 2);
    repeat (12) tick();
    check_stream("t1");
    if (out_cyc.size() == 6) begin
      check_val("t1_gap01", out_cyc[1] - out_cyc[0], 1);
      check_val("t1_gap12", out_cyc[2] - out_cyc[1], 1);
      check_val("t1_gap23", out_cyc[3] - out_cyc[2], 2);
      check_val("t1_gap45", out_cyc[5] - out_cyc[4], 1);
    end
    check_val("t1_ngrants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_val("t1_grant0", grant_log[0], 0);
      check_val("t1_grant1", grant_log[1], 2);
    end
    check_val("t1_beats", beat_total, 6);

    // Forced release after 16 beats, then re-grant of the same source.
    do_reset();
    for (int j = 0; j < 20; j++) push_beat(1, 64'h100 + j, 1'b0);
    drive_sources();
    for (int j = 0; j < 20; j++) expect_beat(64'h100 + j, j == 15);
    repeat (30) tick();
    check_stream("t2");
    if (out_cyc.size() == 20) check_val("t2_bubble", out_cyc[16] - out_cyc[15], 2);
    check_val("t2_ngrants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_val("t2_grant0", grant_log[0], 1);
      check_val("t2_grant1", grant_log[1], 1);
    end
    check_val("t2_beats", beat_total, 20);

    // Output backpressure 1,0,0,1 during a packet.
    do_reset();
    for (int j = 0; j < 4; j++) push_beat(0, 64'hD0 + j, j == 3);
    drive_sources();
    for (int j = 0; j < 4; j++) expect_beat(64'hD0 + j, j == 3);
    for (int k = 0; k < 12; k++) begin
      axis.m_axis_tready = !(k == 3 || k == 4);
      tick();
      if (k == 3 || k == 4) begin
        check_val($sformatf("t3_stall_valid%0d", k), smp_mvalid, 1);
        check_val($sformatf("t3_stall_data%0d", k), smp_mdata, 64'hD1);
        check_val($sformatf("t3_stall_sready%0d", k), smp_sready, 0);
      end
    end
    check_stream("t3");
    check_val("t3_beats", beat_total, 4);

    // Source 3 disabled after two accepted beats.
    do_reset();
    for (int j = 0; j < 5; j++) push_beat(3, 64'hE0 + j, j == 4);
    drive_sources();
    repeat (3) tick();
    axis.src_enable[3] = 1'b0;
    push_beat(1, 64'hB0, 1'b0);
    push_beat(1, 64'hB1, 1'b1);
    drive_sources();
    tick();
    check_val("t4_sready_drop", smp_sready, 0);
    repeat (10) tick();
    expect_beat(64'hE0, 1'b0);
    expect_beat(64'hE1, 1'b0);
    expect_beat(64'hB0, 1'b0);
    expect_beat(64'hB1, 1'b1);
    check_stream("t4");
    check_val("t4_src3_consumed", rp[3], 2);
    check_val("t4_ngrants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_val("t4_grant0", grant_log[0], 3);
      check_val("t4_grant1", grant_log[1], 1);
    end

    // Fairness with all sources sending one-beat packets.
    do_reset();
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < 6; j++) push_beat(i, 64'h1000 * (i + 1) + j, 1'b1);
    drive_sources();
    for (int t = 0; t < 60 && grant_log.size() < 16; t++) tick();
    check_val("t5_enough_grants", grant_log.size() >= 16, 1);
    for (int g = 0; g < 16; g++) begin
      if (g < grant_log.size()) check_val($sformatf("t5_grant%0d", g), grant_log[g], g % 4);
    end

    // Asynchronous reset in the middle of a packet.
    do_reset();
    for (int j = 0; j < 6; j++) push_beat(0, 64'hF0 + j, j == 5);
    drive_sources();
    repeat (3) tick();
    check_val("t6_pre_valid", axis.m_axis_tvalid, 1);
    check_val("t6_pre_gactive", grant_active, 1);
    reset = 1'b1;
    #1;
    check_val("t6_rst_mvalid", axis.m_axis_tvalid, 0);
    check_val("t6_rst_sready", axis.s_axis_tready, 0);
    check_val("t6_rst_gactive", grant_active, 0);
    check_val("t6_rst_beats", beat_total, 0);
    push_beat(2, 64'h2A, 1'b1);
    drive_sources();
    repeat (2) tick();
    clear_logs();
    reset = 1'b0;
    repeat (12) tick();
    check_val("t6_ngrants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check_val("t6_grant0", grant_log[0], 0);
      check_val("t6_grant1", grant_log[1], 2);
    end
    check_val("t6_nbeats", out_data.size(), 5);
    if (out_data.size() >= 1) check_val("t6_first", out_data[0], 64'hF2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
